// File: rtl/ifid_skid_stage_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : ifid_skid_stage_if
// Brief    : Fetch/decode handshake and payload bundle for the IF/ID skid stage.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
interface ifid_skid_stage_if #(
   parameter int PC_W    = 16,
   parameter int INSTR_W = 16,
   parameter int OPC_W   = 3,
   parameter int REG_W   = 3,
   parameter int FUNCT_W = 4,
   parameter int FCNT_W  = 8
);
   logic               in_valid_i;
   logic               in_ready_o;
   logic [PC_W-1:0]    next_pc_i;
   logic [INSTR_W-1:0] instr_i;
   logic               flush_i;
   logic               out_valid_o;
   logic               out_ready_i;
   logic [PC_W-1:0]    next_pc_o;
   logic [OPC_W-1:0]   opcode_o;
   logic [REG_W-1:0]   rs_o;
   logic [REG_W-1:0]   rt_o;
   logic [REG_W-1:0]   rd_o;
   logic [FUNCT_W-1:0] funct_o;
   logic [1:0]         occupancy_o;
   logic [FCNT_W-1:0]  flush_cnt_o;

   // The stage itself
   modport slave (
      input  in_valid_i, next_pc_i, instr_i, flush_i, out_ready_i,
      output in_ready_o, out_valid_o, next_pc_o, opcode_o, rs_o, rt_o, rd_o,
             funct_o, occupancy_o, flush_cnt_o
   );

   // The environment driving fetch and decode sides
   modport master (
      output in_valid_i, next_pc_i, instr_i, flush_i, out_ready_i,
      input  in_ready_o, out_valid_o, next_pc_o, opcode_o, rs_o, rt_o, rd_o,
             funct_o, occupancy_o, flush_cnt_o
   );
endinterface
`default_nettype wire

// File: rtl/ifid_skid_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : ifid_skid_stage
// Brief    : IF/ID stage as a two-entry ready/valid skid buffer with field split,
//            synchronous flush, occupancy and saturating flush-event counter.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module ifid_skid_stage #(
   parameter int PC_W    = 16,
   parameter int INSTR_W = 16,
   parameter int OPC_W   = 3,
   parameter int REG_W   = 3,
   parameter int FUNCT_W = 4,
   parameter int FCNT_W  = 8
) (
   input  wire logic         clk_i,
   input  wire logic         rst_n,
   ifid_skid_stage_if.slave  bus
);

   generate
      if (INSTR_W != OPC_W + 3*REG_W + FUNCT_W) begin : g_bad_width
         $error("ifid_skid_stage: INSTR_W must equal OPC_W + 3*REG_W + FUNCT_W");
      end
   endgenerate

   localparam logic [FCNT_W-1:0] FCNT_ONE = 1;

   typedef struct packed {
      logic [PC_W-1:0]    pc;
      logic [OPC_W-1:0]   opcode;
      logic [REG_W-1:0]   rs;
      logic [REG_W-1:0]   rt;
      logic [REG_W-1:0]   rd;
      logic [FUNCT_W-1:0] funct;
   } entry_t;

   logic              out_valid, out_valid_d;
   logic              skid_valid, skid_valid_d;
   entry_t            out_q, out_d;
   entry_t            skid_q, skid_d;
   logic [FCNT_W-1:0] fcnt, fcnt_d;
   entry_t            in_fields;
   logic              in_ready;
   logic              accept;
   logic              pop;

   // Ready is purely registered so there is no ready path back from decode
   assign in_ready = ~skid_valid;
   assign accept   = bus.in_valid_i & in_ready;
   assign pop      = out_valid & bus.out_ready_i;

   always_comb begin
      in_fields        = '0;
      in_fields.pc     = bus.next_pc_i;
      in_fields.opcode = bus.instr_i[INSTR_W-1 -: OPC_W];
      in_fields.rs     = bus.instr_i[INSTR_W-OPC_W-1 -: REG_W];
      in_fields.rt     = bus.instr_i[INSTR_W-OPC_W-REG_W-1 -: REG_W];
      in_fields.rd     = bus.instr_i[INSTR_W-OPC_W-2*REG_W-1 -: REG_W];
      in_fields.funct  = bus.instr_i[FUNCT_W-1:0];
   end

   always_comb begin
      out_valid_d  = out_valid;
      skid_valid_d = skid_valid;
      out_d        = out_q;
      skid_d       = skid_q;
      fcnt_d       = fcnt;
      if (bus.flush_i) begin
         out_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
         out_d        = '0;
         skid_d       = '0;
         if ((out_valid || skid_valid) && (fcnt != '1)) begin
            fcnt_d = fcnt + FCNT_ONE;
         end
      end else if (skid_valid) begin
         if (pop) begin
            out_d        = skid_q;
            skid_valid_d = 1'b0;
            skid_d       = '0;
         end
      end else if (accept && (!out_valid || pop)) begin
         out_d       = in_fields;
         out_valid_d = 1'b1;
      end else if (accept) begin
         skid_d       = in_fields;
         skid_valid_d = 1'b1;
      end else if (pop) begin
         // Zeroed payload lets a bubble decode as a NOP
         out_valid_d = 1'b0;
         out_d       = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         skid_valid <= 1'b0;
         out_q      <= '0;
         skid_q     <= '0;
         fcnt       <= '0;
      end else begin
         out_valid  <= out_valid_d;
         skid_valid <= skid_valid_d;
         out_q      <= out_d;
         skid_q     <= skid_d;
         fcnt       <= fcnt_d;
      end
   end

   assign bus.in_ready_o  = in_ready;
   assign bus.out_valid_o = out_valid;
   assign bus.next_pc_o   = out_q.pc;
   assign bus.opcode_o    = out_q.opcode;
   assign bus.rs_o        = out_q.rs;
   assign bus.rt_o        = out_q.rt;
   assign bus.rd_o        = out_q.rd;
   assign bus.funct_o     = out_q.funct;
   assign bus.occupancy_o = {1'b0, out_valid} + {1'b0, skid_valid};
   assign bus.flush_cnt_o = fcnt;

endmodule
`default_nettype wire

// File: tb/tb_ifid_skid_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_ifid_skid_stage
// Brief    : Directed scoreboard bench for ifid_skid_stage (FCNT_W = 2).
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_ifid_skid_stage;

   localparam int FCNT_W = 2;

   typedef struct {
      logic [15:0] pc;
      logic [15:0] instr;
   } ent_t;

   logic clk_i = 1'b0;
   logic rst_n = 1'b0;

   ifid_skid_stage_if #(.FCNT_W(FCNT_W)) bus ();

   ifid_skid_stage #(.FCNT_W(FCNT_W)) dut (
      .clk_i (clk_i),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk_i = ~clk_i;

   ent_t sb[$];
   int   checks = 0;
   int   passes = 0;
   int   pops   = 0;
   bit   last_acc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic drive(input logic v, input logic [15:0] pc, input logic [15:0] ins);
      bus.in_valid_i = v;
      bus.next_pc_i  = pc;
      bus.instr_i    = ins;
   endtask

   // Handshake bookkeeping just before the edge, then advance to edge + 1
   task automatic tick();
      ent_t e;
      #1;
      last_acc = 1'b0;
      if (rst_n) begin
         if (bus.flush_i) begin
            sb.delete();
         end else begin
            if (!bus.out_valid_o)
               chk("bubble_zero", {bus.next_pc_o, bus.opcode_o, bus.rs_o, bus.rt_o,
                                   bus.rd_o, bus.funct_o}, 32'h0);
            if (bus.out_valid_o && bus.out_ready_i) begin
               pops++;
               if (sb.size() == 0) begin
                  checks++;
                  $error("FAIL sb_extra: observed output pc %0h expected no output", bus.next_pc_o);
               end else begin
                  e = sb.pop_front();
                  chk("pc",     32'(bus.next_pc_o), 32'(e.pc));
                  chk("opcode", 32'(bus.opcode_o),  32'(e.instr[15:13]));
                  chk("rs",     32'(bus.rs_o),      32'(e.instr[12:10]));
                  chk("rt",     32'(bus.rt_o),      32'(e.instr[9:7]));
                  chk("rd",     32'(bus.rd_o),      32'(e.instr[6:4]));
                  chk("funct",  32'(bus.funct_o),   32'(e.instr[3:0]));
               end
            end
            if (bus.in_valid_i && bus.in_ready_o) begin
               e.pc = bus.next_pc_i;
               e.instr = bus.instr_i;
               sb.push_back(e);
               last_acc = 1'b1;
            end
         end
      end
      @(posedge clk_i);
      #1;
   endtask

   task automatic fill_two(input logic [15:0] base);
      bus.out_ready_i = 1'b0;
      drive(1'b1, base, base ^ 16'h3C5A);
      tick();
      drive(1'b1, base + 16'd1, base ^ 16'hC3A5);
      tick();
      drive(1'b0, 16'h0, 16'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: observed no finish expected finish before 100000");
      $fatal(1, "timeout");
   end

   logic [15:0] stream_ins [4] = '{16'h1234, 16'hFEDC, 16'h0F0F, 16'h8001};
   int sent;
   int pops0;
   int guard;

   initial begin
      bus.flush_i = 1'b0;
      bus.out_ready_i = 1'b0;
      drive(1'b0, 16'h0, 16'h0);
      repeat (2) @(posedge clk_i);
      #1;
      chk("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
      chk("rst_in_ready",  32'(bus.in_ready_o),  32'd1);
      chk("rst_occ",       32'(bus.occupancy_o), 32'd0);
      chk("rst_fcnt",      32'(bus.flush_cnt_o), 32'd0);
      chk("rst_payload",   {bus.next_pc_o, bus.opcode_o, bus.rs_o, bus.rt_o, bus.rd_o,
                            bus.funct_o}, 32'h0);
      rst_n = 1'b1;
      @(posedge clk_i);
      #1;

      // Single instruction, one-cycle latency
      bus.out_ready_i = 1'b1;
      drive(1'b1, 16'h0011, 16'hA5C3);
      tick();
      drive(1'b0, 16'h0, 16'h0);
      chk("t1_valid",  32'(bus.out_valid_o), 32'd1);
      chk("t1_opcode", 32'(bus.opcode_o),    32'h5);
      chk("t1_rs",     32'(bus.rs_o),        32'h1);
      chk("t1_rt",     32'(bus.rt_o),        32'h3);
      chk("t1_rd",     32'(bus.rd_o),        32'h4);
      chk("t1_funct",  32'(bus.funct_o),     32'h3);
      chk("t1_pc",     32'(bus.next_pc_o),   32'h0011);
      chk("t1_occ",    32'(bus.occupancy_o), 32'd1);
      tick();
      chk("t1_drained", 32'(bus.out_valid_o), 32'd0);

      // Back-pressured stream of four
      pops0 = pops;
      sent = 0;
      bus.out_ready_i = 1'b0;
      for (int c = 0; c < 4; c++) begin
         drive(sent < 4, 16'h0100 + 16'(sent), stream_ins[sent < 4 ? sent : 0]);
         tick();
         if (last_acc) sent++;
      end
      chk("bp_sent",     32'(sent),            32'd2);
      chk("bp_in_ready", 32'(bus.in_ready_o),  32'd0);
      chk("bp_occ",      32'(bus.occupancy_o), 32'd2);
      bus.out_ready_i = 1'b1;
      guard = 0;
      while ((sent < 4 || sb.size() != 0) && guard < 30) begin
         drive(sent < 4, 16'h0100 + 16'(sent), stream_ins[sent < 4 ? sent : 0]);
         tick();
         if (last_acc) sent++;
         guard++;
      end
      drive(1'b0, 16'h0, 16'h0);
      chk("bp_no_timeout", 32'(guard < 30), 32'd1);
      chk("bp_pops",       32'(pops - pops0), 32'd4);

      // Flush with two entries and a concurrent input
      fill_two(16'h0200);
      chk("fl_occ_pre", 32'(bus.occupancy_o), 32'd2);
      bus.flush_i = 1'b1;
      drive(1'b1, 16'h0AAA, 16'h7777);
      tick();
      bus.flush_i = 1'b0;
      drive(1'b0, 16'h0, 16'h0);
      chk("fl_valid",    32'(bus.out_valid_o), 32'd0);
      chk("fl_payload",  {bus.next_pc_o, bus.opcode_o, bus.rs_o, bus.rt_o, bus.rd_o,
                          bus.funct_o}, 32'h0);
      chk("fl_occ",      32'(bus.occupancy_o), 32'd0);
      chk("fl_in_ready", 32'(bus.in_ready_o),  32'd1);
      chk("fl_cnt",      32'(bus.flush_cnt_o), 32'd1);
      pops0 = pops;
      bus.out_ready_i = 1'b1;
      tick();
      tick();
      chk("fl_dropped", 32'(pops - pops0), 32'd0);

      // Flushing an empty stage does not count
      bus.flush_i = 1'b1;
      tick();
      bus.flush_i = 1'b0;
      chk("fl_empty_cnt", 32'(bus.flush_cnt_o), 32'd1);

      // Four more discarding flushes saturate a 2-bit counter at 3
      for (int k = 0; k < 4; k++) begin
         bus.out_ready_i = 1'b0;
         drive(1'b1, 16'h0300 + 16'(k), 16'h1111 * 16'(k + 1));
         tick();
         drive(1'b0, 16'h0, 16'h0);
         bus.flush_i = 1'b1;
         tick();
         bus.flush_i = 1'b0;
      end
      chk("fl_sat", 32'(bus.flush_cnt_o), 32'd3);

      // One pop from a full stage moves skid to output
      fill_two(16'h0400);
      bus.out_ready_i = 1'b1;
      tick();
      bus.out_ready_i = 1'b0;
      chk("sk_occ",      32'(bus.occupancy_o), 32'd1);
      chk("sk_in_ready", 32'(bus.in_ready_o),  32'd1);
      chk("sk_valid",    32'(bus.out_valid_o), 32'd1);
      bus.out_ready_i = 1'b1;
      tick();
      chk("sk_empty", 32'(sb.size()), 32'd0);

      // Asynchronous reset between edges
      fill_two(16'h0500);
      #3;
      rst_n = 1'b0;
      #1;
      chk("ar_valid", 32'(bus.out_valid_o), 32'd0);
      chk("ar_occ",   32'(bus.occupancy_o), 32'd0);
      chk("ar_fcnt",  32'(bus.flush_cnt_o), 32'd0);
      chk("ar_pc",    32'(bus.next_pc_o),   32'd0);
      chk("ar_ready", 32'(bus.in_ready_o),  32'd1);
      sb.delete();
      @(posedge clk_i);
      #1;
      rst_n = 1'b1;
      tick();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
`default_nettype wire
